fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32I pipeline, directly upstream of decode (register file and control decode).
- Holds the PC and issues requests to instruction memory over a valid/ready handshake, with one request outstanding at a time.
- Feeds the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) consumed by the decode stage.
- Handles decode stalls through a 1-entry hold buffer; handles branch/jump redirects from execute by killing wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, instruction word driven on InstrD when invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- StallD  in  1  decode stalled: IF/ID register must hold its contents.
- FlushD  in  1  invalidate IF/ID register next edge.
- PCSrcE  in  1  redirect request from execute (taken branch or jump).
- PCTargetE  in  32  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address (PCF).
- imem_rsp_valid  in  1  response valid; arrives at least 1 cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- PCF  out  32  current fetch PC.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (rst=1 at edge):
  - PCF=RESET_PC, state=S_ISSUE, drop=0, buffer empty.
  - ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
  - imem_req_valid forced 0 while rst=1.
  - Reset mid-transaction abandons any outstanding request. The memory must also be reset, so no stale response arrives.
- States: S_ISSUE, S_WAIT, S_HOLD.
  - S_ISSUE: imem_req_valid=1, imem_addr=PCF. On valid&ready: pc_inflight<=PCF, PCF<=PCF+4, go to S_WAIT.
  - S_WAIT: req_valid=0. On rsp_valid:
    - drop=1: discard the response, clear drop, go to S_ISSUE.
    - drop=0 and StallD=0: load IF/ID with InstrD=data, PCD=pc_inflight, PCPlus4D=pc_inflight+4, ValidD=1; go to S_ISSUE.
    - drop=0 and StallD=1: store data and pc_inflight in the buffer, go to S_HOLD.
  - S_HOLD: req_valid=0. When StallD=0: move the buffer into IF/ID with ValidD=1, go to S_ISSUE.
- IF/ID update rule:
  - StallD=1: hold all fields.
  - StallD=0 with no instruction delivered this cycle: ValidD<=0, InstrD<=NOP_INSTR; PCD/PCPlus4D don't-care but held.
- Redirect (PCSrcE=1) overrides all state logic:
  - PCF<=PCTargetE; buffer discarded; IF/ID invalidated (ValidD<=0, InstrD<=NOP_INSTR) regardless of StallD.
  - S_ISSUE with handshake in the same cycle: go to S_WAIT with drop=1.
  - S_ISSUE without handshake: stay in S_ISSUE.
  - S_WAIT with rsp_valid in the same cycle: discard the response, go to S_ISSUE, drop=0.
  - S_WAIT without rsp_valid: stay in S_WAIT, drop=1.
  - S_HOLD: go to S_ISSUE.
- FlushD=1 (no redirect): ValidD<=0, InstrD<=NOP_INSTR, overriding StallD. Any instruction delivered that cycle is discarded; a buffered instruction is also discarded (S_HOLD to S_ISSUE). PCF is unaffected.
- Arithmetic: 32-bit PC+4 wraps modulo 2^32 (32'hFFFF_FFFC goes to 0). No alignment check on PCTargetE.
- Throughput: best case one instruction per 2 cycles with 1-cycle memory latency.

Optional Feature:
- Macro FETCH_BUBBLE_CNT_EN.
- Defined:
  - Adds output port BubbleCnt [31:0], reset to 0.
  - Increments each cycle that StallD=0 and the IF/ID register loads ValidD=0; wraps at 2^32.
  - Excludes cycles with rst=1.
- Undefined: no port and no counter logic.

Test Plan:
- Reset then 1-cycle memory, StallD=0, RESET_PC=0 -> requests at 0x0, 0x4, 0x8; ValidD pulses with PCD=0x0/0x4/0x8, PCPlus4D=0x4/0x8/0xC; ValidD=0 after reset.
- Memory holds imem_req_ready=0 for 3 cycles -> imem_addr stable at 0x0 and PCF unchanged until acceptance; no ValidD until the response arrives.
- Response 0x00500093 arrives while StallD=1 for 4 cycles -> IF/ID holds the prior entry; state S_HOLD; on StallD=0, InstrD=0x00500093 with ValidD=1 next edge; no new request issued while in S_HOLD.
- PCSrcE=1, PCTargetE=0x100 in S_WAIT, response arrives next cycle -> response dropped, ValidD=0, next request address 0x100, delivered PCD=0x100.
- PCSrcE=1 and rsp_valid in the same cycle, StallD=1 -> response discarded, ValidD=0 despite the stall, next imem_addr=PCTargetE.
- PCF=0xFFFF_FFFC fetched -> PCF wraps to 0x0000_0000, PCPlus4D=0x0; with FETCH_BUBBLE_CNT_EN defined, BubbleCnt counts exactly the non-valid unstalled IF/ID loads (e.g. 1 per fetch at 1-cycle latency).

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage.
// Keeps the fetch PC and issues one instruction-memory request at a time over a
// valid/ready handshake. Fetched words go into the IF/ID register, through a
// 1-entry hold buffer when decode is stalled. Execute redirects kill wrong-path
// fetches.
// Optional: define FETCH_BUBBLE_CNT_EN to add the BubbleCnt output, which counts
// unstalled cycles where IF/ID loads an invalid entry.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_BUBBLE_CNT_EN
    ,
    output logic [31:0] BubbleCnt
`endif
);

    localparam int unsigned XLEN    = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    localparam logic [1:0] S_ISSUE = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]      state_q,       state_d;
    logic [XLEN-1:0] pcf_q,         pcf_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            drop_q,        drop_d;
    logic [XLEN-1:0] buf_instr_q,   buf_instr_d;
    logic [XLEN-1:0] buf_pc_q,      buf_pc_d;
    logic            ifid_valid_q,  ifid_valid_d;
    logic [XLEN-1:0] ifid_instr_q,  ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q,     ifid_pc_d;
    logic [XLEN-1:0] ifid_pcp4_q,   ifid_pcp4_d;

    logic            handshake;
    logic            deliver;
    logic [XLEN-1:0] dlv_instr;
    logic [XLEN-1:0] dlv_pc;

    // Request is a pure decode of the state, suppressed while reset is asserted
    assign imem_req_valid = (state_q == S_ISSUE) && !rst;
    assign imem_addr      = pcf_q;
    assign handshake      = (state_q == S_ISSUE) && imem_req_ready;

    // Next-state, fetch PC, hold buffer and IF/ID next values
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        pc_inflight_d = pc_inflight_q;
        drop_d        = drop_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pcp4_d   = ifid_pcp4_q;
        deliver       = 1'b0;
        dlv_instr     = imem_rsp_data;
        dlv_pc        = pc_inflight_q;

        case (state_q)
            S_ISSUE: begin
                if (handshake) begin
                    pc_inflight_d = pcf_q;
                    pcf_d         = pcf_q + PC_STEP;
                    drop_d        = 1'b0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_ISSUE;
                    drop_d  = 1'b0;
                    // A flushed or killed response is simply not kept
                    if (!drop_q && !FlushD) begin
                        if (StallD) begin
                            buf_instr_d = imem_rsp_data;
                            buf_pc_d    = pc_inflight_q;
                            state_d     = S_HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (FlushD) begin
                    state_d = S_ISSUE;
                end else if (!StallD) begin
                    deliver   = 1'b1;
                    dlv_instr = buf_instr_q;
                    dlv_pc    = buf_pc_q;
                    state_d   = S_ISSUE;
                end
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase

        // Redirect from execute wins over everything above
        if (PCSrcE) begin
            pcf_d   = PCTargetE;
            deliver = 1'b0;
            case (state_q)
                S_ISSUE: begin
                    state_d = handshake ? S_WAIT : S_ISSUE;
                    drop_d  = handshake;
                end
                S_WAIT: begin
                    state_d = imem_rsp_valid ? S_ISSUE : S_WAIT;
                    drop_d  = !imem_rsp_valid;
                end
                default: begin
                    state_d = S_ISSUE;
                    drop_d  = 1'b0;
                end
            endcase
        end

        // IF/ID: kill on redirect/flush, else hold on stall, else load or bubble
        if (PCSrcE || FlushD) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!StallD) begin
            if (deliver) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = dlv_instr;
                ifid_pc_d    = dlv_pc;
                ifid_pcp4_d  = dlv_pc + PC_STEP;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ISSUE;
            pcf_q         <= RESET_PC;
            pc_inflight_q <= '0;
            drop_q        <= 1'b0;
            buf_instr_q   <= '0;
            buf_pc_q      <= '0;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_pc_q     <= '0;
            ifid_pcp4_q   <= '0;
        end else begin
            state_q       <= state_d;
            pcf_q         <= pcf_d;
            pc_inflight_q <= pc_inflight_d;
            drop_q        <= drop_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pcp4_q   <= ifid_pcp4_d;
        end
    end

    assign PCF      = pcf_q;
    assign InstrD   = ifid_instr_q;
    assign PCD      = ifid_pc_q;
    assign PCPlus4D = ifid_pcp4_q;
    assign ValidD   = ifid_valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [XLEN-1:0] bubble_q, bubble_d;

    // Count unstalled cycles that load a bubble into IF/ID
    always_comb begin
        bubble_d = bubble_q;
        if (!StallD && !ifid_valid_d) begin
            bubble_d = bubble_q + XLEN'(1);
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign BubbleCnt = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a transaction-level
// reference model and an instruction-memory responder of programmable latency.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] BubbleCnt;
`endif

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .PCF            (PCF),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
`ifdef FETCH_BUBBLE_CNT_EN
        .BubbleCnt      (BubbleCnt),
`endif
        .ValidD         (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    int          mem_lat = 1;
    int          rdy_from = 0;
    int          cyc = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    bit          acc_flag = 0;
    logic [31:0] last_acc = '0;

    always @(posedge clk) begin
        logic        a;
        logic [31:0] ad;
        a  = imem_req_valid && imem_req_ready;
        ad = imem_addr;
        #1;
        cyc++;
        acc_flag       = 0;
        imem_rsp_valid = 1'b0;
        if (rst) begin
            pend = 0;
        end else begin
            if (a) begin
                pend = 1; cnt = mem_lat; paddr = ad; acc_flag = 1; last_acc = ad;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    pend = 0;
                end
            end
        end
        imem_req_ready = (cyc >= rdy_from);
    end

    // ---------------- reference model ----------------
    bit          m_on = 0;
    logic [31:0] m_pc, m_inpc, m_hi, m_hp;
    bit          m_busy, m_kill, m_held;
    logic        m_valid;
    logic [31:0] m_instr, m_pcd, m_pcp4, m_bub;

    always @(posedge clk) begin
        bit          fire, got, dlv;
        logic [31:0] di, dp;
        if (rst) begin
            m_on = 1; m_pc = 32'h0; m_inpc = '0; m_hi = '0; m_hp = '0;
            m_busy = 0; m_kill = 0; m_held = 0;
            m_valid = 1'b0; m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_bub = '0;
        end else if (m_on) begin
            fire = !m_busy && !m_held && imem_req_ready;
            got  = m_busy && imem_rsp_valid;
            dlv = 0; di = '0; dp = '0;
            if (PCSrcE) begin
                if (fire)        begin m_busy = 1; m_kill = 1; end
                else if (got)    begin m_busy = 0; m_kill = 0; end
                else if (m_busy) m_kill = 1;
                m_held = 0;
                m_pc   = PCTargetE;
            end else if (fire) begin
                m_inpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_kill = 0;
            end else if (got) begin
                m_busy = 0;
                if (m_kill) m_kill = 0;
                else if (!FlushD) begin
                    if (StallD) begin m_held = 1; m_hi = imem_rsp_data; m_hp = m_inpc; end
                    else begin dlv = 1; di = imem_rsp_data; dp = m_inpc; end
                end
            end else if (m_held && (FlushD || !StallD)) begin
                m_held = 0;
                if (!FlushD) begin dlv = 1; di = m_hi; dp = m_hp; end
            end
            if (PCSrcE || FlushD) begin
                m_valid = 1'b0; m_instr = NOP;
            end else if (!StallD) begin
                m_valid = dlv;
                m_instr = dlv ? di : NOP;
                if (dlv) begin m_pcd = dp; m_pcp4 = dp + 32'd4; end
            end
            if (!StallD && !m_valid) m_bub = m_bub + 32'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_on) begin
            chk("PCF", PCF, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, (!m_busy && !m_held && !rst)});
            chk("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
            chk("InstrD", InstrD, m_instr);
            chk("PCD", PCD, m_pcd);
            chk("PCPlus4D", PCPlus4D, m_pcp4);
`ifdef FETCH_BUBBLE_CNT_EN
            chk("BubbleCnt", BubbleCnt, m_bub);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(output logic [31:0] a);
        bit seen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (acc_flag) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL accept_timeout: got none want handshake at %0t", $time);
        end
        a = last_acc;
    endtask

    task automatic wait_accept_addr(input logic [31:0] want);
        logic [31:0] a = '0;
        for (int n = 0; n < 5; n++) begin
            wait_accept(a);
            if (a == want) break;
        end
        chk("accept_addr", a, want);
    endtask

    task automatic wait_valid(output logic [31:0] pcd, output logic [31:0] p4, output logic [31:0] ins);
        bit seen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (ValidD === 1'b1) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL valid_timeout: got none want ValidD at %0t", $time);
        end
        pcd = PCD; p4 = PCPlus4D; ins = InstrD;
    endtask

    initial begin
        logic [31:0] pcd, p4, ins, a;
        logic [31:0] exp_pcd [3];
        logic [31:0] b0;
        exp_pcd[0] = 32'h0; exp_pcd[1] = 32'h4; exp_pcd[2] = 32'h8;
        b0 = '0;

        // Reset values
        tick(); tick();
        chk("rst_ValidD", {31'b0, ValidD}, 32'h0);
        chk("rst_InstrD", InstrD, NOP);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_PCF", PCF, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        rst = 1'b0;

        // Straight-line fetch with 1-cycle memory
        for (int i = 0; i < 3; i++) begin
            wait_valid(pcd, p4, ins);
            chk("seq_PCD", pcd, exp_pcd[i]);
            chk("seq_PCPlus4D", p4, exp_pcd[i] + 32'd4);
            chk("seq_InstrD", ins, exp_pcd[i] ^ 32'hC0DE_0000);
        end

        // Memory not ready for 3 active cycles after reset
        rst = 1'b1; rdy_from = cyc + 4;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h0);
            chk("stall_PCF", PCF, 32'h0);
            chk("stall_ValidD", {31'b0, ValidD}, 32'h0);
        end
        wait_valid(pcd, p4, ins);
        chk("late_PCD", pcd, 32'h0);

        // Response lands during a 4-cycle decode stall
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        wait_accept_addr(32'h200);
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_req_valid", {31'b0, imem_req_valid}, 32'h0);
            chk("hold_ValidD", {31'b0, ValidD}, 32'h0);
        end
        StallD = 1'b0;
        tick();
        chk("hold_out_ValidD", {31'b0, ValidD}, 32'h1);
        chk("hold_out_InstrD", InstrD, 32'h0050_0093);
        chk("hold_out_PCD", PCD, 32'h200);

        // Flush while holding a buffered instruction discards it
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        wait_accept_addr(32'h200);
        StallD = 1'b1;
        tick(); tick();
        FlushD = 1'b1;
        tick();
        FlushD = 1'b0; StallD = 1'b0;
        chk("flush_ValidD", {31'b0, ValidD}, 32'h0);
        wait_accept(a);
        chk("flush_next_addr", a, 32'h204);

        // Redirect while waiting; response next cycle is dropped
        mem_lat = 2;
        wait_accept(a);
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        tick();
        PCSrcE = 1'b0;
        tick();
        chk("drop_ValidD", {31'b0, ValidD}, 32'h0);
        wait_accept(a);
        chk("redir_addr", a, 32'h100);
        wait_valid(pcd, p4, ins);
        chk("redir_PCD", pcd, 32'h100);

        // Redirect coincident with response under a stall
        mem_lat = 1;
        wait_accept(a);
        PCSrcE = 1'b1; PCTargetE = 32'h300; StallD = 1'b1;
        tick();
        PCSrcE = 1'b0; StallD = 1'b0;
        chk("coinc_ValidD", {31'b0, ValidD}, 32'h0);
        chk("coinc_InstrD", InstrD, NOP);
        chk("coinc_addr", imem_addr, 32'h300);
        chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'h1);

        // PC wrap at the top of the address space
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        PCSrcE = 1'b0;
        wait_accept_addr(32'hFFFF_FFFC);
        chk("wrap_PCF", PCF, 32'h0);
        wait_valid(pcd, p4, ins);
        chk("wrap_PCD", pcd, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D", p4, 32'h0);
        chk("wrap_InstrD", ins, 32'h3F21_FFFC);
        wait_valid(pcd, p4, ins);
        chk("wrap_next_PCD", pcd, 32'h0);
`ifdef FETCH_BUBBLE_CNT_EN
        b0 = BubbleCnt;
        for (int i = 0; i < 4; i++) wait_valid(pcd, p4, ins);
        chk("bubble_delta", BubbleCnt - b0, 32'd4);
`endif

        // Reset in the middle of an outstanding request
        mem_lat = 3;
        wait_accept(a);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_PCF", PCF, 32'h0);
        chk("midrst_ValidD", {31'b0, ValidD}, 32'h0);
        mem_lat = 1;
        wait_valid(pcd, p4, ins);
        chk("midrst_PCD", pcd, 32'h0);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a wait ever escapes its bound
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
